// File: rtl/piso_serial_feeder.sv
// Parallel-in serial-out feeder for the downstream SIPO.
// Sends MSB first with a qualifying strobe, then pulses word-done.
module piso_serial_feeder #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  input  logic             Data_Valid_In,
  output logic             Data_Ready_Out,
  output logic             Serial_Data_Out,
  output logic             Shift_Data_Signal_Out,
  output logic             Word_Done_Out,
  output logic             Busy_Out
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ?
                      $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BW-1:0] BIT_INIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_INIT =
    (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             ser_q, ser_d;
  logic             shf_q, shf_d;
  logic             done_q, done_d;
  logic             accept;

  assign Data_Ready_Out = Enable_In & (state_q == S_IDLE);
  assign accept         = Data_Valid_In & Data_Ready_Out;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    ser_d   = ser_q;
    shf_d   = shf_q;
    done_d  = done_q;
    if (Enable_In) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sreg_d  = Parallel_Data_In;
            bcnt_d  = BIT_INIT;
            ser_d   = Parallel_Data_In[WIDTH-1];
            shf_d   = 1'b1;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bcnt_q != '0) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            ser_d  = sreg_q[WIDTH-2];
            bcnt_d = bcnt_q - BW'(1);
          end else begin
            shf_d   = 1'b0;
            ser_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          done_d = 1'b0;
          gcnt_d = GAP_INIT;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
        default: begin
          if (gcnt_q == '0) state_d = S_IDLE;
          else gcnt_d = gcnt_q - GW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      ser_q   <= 1'b0;
      shf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      ser_q   <= ser_d;
      shf_q   <= shf_d;
      done_q  <= done_d;
    end
  end

  // Frozen strobes stay registered so they re-appear on re-enable.
  assign Serial_Data_Out       = ser_q;
  assign Shift_Data_Signal_Out = shf_q & Enable_In;
  assign Word_Done_Out         = done_q & Enable_In;
  assign Busy_Out              = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serial_feeder.sv
// Directed bench for piso_serial_feeder with a negedge SIPO model.
// Three instances: 4-bit gap 1, 4-bit gap 0, 8-bit gap 1.
module tb_piso_serial_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic a_en, a_vld, a_rdy, a_ser, a_shf, a_done, a_busy;
  logic b_en, b_vld, b_rdy, b_ser, b_shf, b_done, b_busy;
  logic c_en, c_vld, c_rdy, c_ser, c_shf, c_done, c_busy;
  logic [3:0] a_dat, b_dat, a_sipo, b_sipo;
  logic [7:0] c_dat, c_sipo;

  int checks = 0;
  int errors = 0;

  piso_serial_feeder #(.WIDTH(4), .GAP_CYCLES(1)) u_a (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(a_en),
    .Parallel_Data_In(a_dat), .Data_Valid_In(a_vld),
    .Data_Ready_Out(a_rdy), .Serial_Data_Out(a_ser),
    .Shift_Data_Signal_Out(a_shf), .Word_Done_Out(a_done),
    .Busy_Out(a_busy));

  piso_serial_feeder #(.WIDTH(4), .GAP_CYCLES(0)) u_b (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(b_en),
    .Parallel_Data_In(b_dat), .Data_Valid_In(b_vld),
    .Data_Ready_Out(b_rdy), .Serial_Data_Out(b_ser),
    .Shift_Data_Signal_Out(b_shf), .Word_Done_Out(b_done),
    .Busy_Out(b_busy));

  piso_serial_feeder #(.WIDTH(8), .GAP_CYCLES(1)) u_c (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(c_en),
    .Parallel_Data_In(c_dat), .Data_Valid_In(c_vld),
    .Data_Ready_Out(c_rdy), .Serial_Data_Out(c_ser),
    .Shift_Data_Signal_Out(c_shf), .Word_Done_Out(c_done),
    .Busy_Out(c_busy));

  // Downstream SIPOs sample on the falling edge
  always @(negedge clk or posedge rst)
    if (rst) a_sipo <= '0;
    else if (a_shf) a_sipo <= {a_sipo[2:0], a_ser};
  always @(negedge clk or posedge rst)
    if (rst) b_sipo <= '0;
    else if (b_shf) b_sipo <= {b_sipo[2:0], b_ser};
  always @(negedge clk or posedge rst)
    if (rst) c_sipo <= '0;
    else if (c_shf) c_sipo <= {c_sipo[6:0], c_ser};

  task automatic chk(input string nm, input int cyc,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_check();
    @(negedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       en;
    logic       vld;
    logic [3:0] dat;
    logic       rdy;
    logic       ser;
    logic       shf;
    logic       done;
    logic       busy;
    logic       cs;
    logic [3:0] sipo;
  } vec_t;

  vec_t tv [9];

  initial begin
    int nshf, ndone;
    logic [7:0] bits;
    logic exp_shf, exp_done, exp_rdy, exp_busy;

    tv[0] = '{1'b1, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tv[1] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    tv[2] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    tv[3] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    tv[4] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    tv[5] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hB};
    tv[6] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    tv[7] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tv[8] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

    rst = 1'b1;
    a_en = 1'b1; a_vld = 1'b0; a_dat = '0;
    b_en = 1'b0; b_vld = 1'b0; b_dat = '0;
    c_en = 1'b0; c_vld = 1'b0; c_dat = '0;
    repeat (2) to_check();
    chk("rst_ser", 0, a_ser, 0);
    chk("rst_shf", 0, a_shf, 0);
    chk("rst_done", 0, a_done, 0);
    chk("rst_busy", 0, a_busy, 0);
    chk("rst_rdy", 0, a_rdy, 1);
    chk("rst_b_busy", 0, b_busy, 0);
    chk("rst_c_ser", 0, c_ser, 0);
    rst = 1'b0;

    // Basic word, valid while busy, data change after accept
    for (int i = 0; i < 9; i++) begin
      to_drive();
      a_en = tv[i].en; a_vld = tv[i].vld; a_dat = tv[i].dat;
      to_check();
      chk("tv_rdy", i, a_rdy, tv[i].rdy);
      chk("tv_ser", i, a_ser, tv[i].ser);
      chk("tv_shf", i, a_shf, tv[i].shf);
      chk("tv_done", i, a_done, tv[i].done);
      chk("tv_busy", i, a_busy, tv[i].busy);
      if (tv[i].cs) chk("tv_sipo", i, a_sipo, tv[i].sipo);
    end

    // Back-to-back on the gapless instance
    b_en = 1'b1;
    nshf = 0;
    for (int c = 0; c < 14; c++) begin
      to_drive();
      b_vld = (c <= 6);
      b_dat = (c <= 5) ? 4'hA : 4'h5;
      to_check();
      exp_rdy  = (c == 0 || c == 6 || c >= 12);
      exp_done = (c == 5 || c == 11);
      exp_shf  = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      chk("b2b_rdy", c, b_rdy, exp_rdy);
      chk("b2b_shf", c, b_shf, exp_shf);
      chk("b2b_done", c, b_done, exp_done);
      if (b_shf) nshf++;
      if (c == 5) chk("b2b_sipo1", c, b_sipo, 4'hA);
      if (c == 11) chk("b2b_sipo2", c, b_sipo, 4'h5);
    end
    chk("b2b_nshf", 0, nshf, 8);
    b_vld = 1'b0;

    // Enable dropped mid-word and during the done cycle
    nshf = 0; ndone = 0;
    for (int c = 0; c < 13; c++) begin
      to_drive();
      a_en  = !(c == 3 || c == 4 || c == 5 || c == 8 || c == 9);
      a_vld = (c == 0);
      a_dat = 4'hC;
      to_check();
      exp_shf  = (c == 1 || c == 2 || c == 6 || c == 7);
      exp_done = (c == 10);
      exp_busy = (c >= 1 && c <= 11);
      exp_rdy  = (c == 0 || c == 12);
      chk("en_shf", c, a_shf, exp_shf);
      chk("en_done", c, a_done, exp_done);
      chk("en_busy", c, a_busy, exp_busy);
      chk("en_rdy", c, a_rdy, exp_rdy);
      if (a_shf) nshf++;
      if (a_done) ndone++;
      if (c == 10) chk("en_sipo", c, a_sipo, 4'hC);
    end
    chk("en_nshf", 0, nshf, 4);
    chk("en_ndone", 0, ndone, 1);
    a_vld = 1'b0;

    // Asynchronous reset in the middle of a word
    for (int c = 0; c < 3; c++) begin
      to_drive();
      a_en = 1'b1; a_vld = (c == 0); a_dat = 4'h6;
      to_check();
    end
    chk("pre_rst_busy", 0, a_busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_ser", 0, a_ser, 0);
    chk("arst_shf", 0, a_shf, 0);
    chk("arst_done", 0, a_done, 0);
    chk("arst_busy", 0, a_busy, 0);
    #1 rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      to_drive();
      a_vld = 1'b0;
      to_check();
      if (a_done) ndone++;
    end
    chk("arst_nodone", 0, ndone, 0);
    for (int c = 0; c < 8; c++) begin
      to_drive();
      a_vld = (c == 0); a_dat = 4'h9;
      to_check();
      chk("post_done", c, a_done, (c == 5));
      if (c == 5) chk("post_sipo", c, a_sipo, 4'h9);
    end
    a_vld = 1'b0;

    // 8-bit instance
    c_en = 1'b1;
    nshf = 0; bits = '0;
    for (int c = 0; c < 12; c++) begin
      to_drive();
      c_vld = (c == 0); c_dat = 8'hC3;
      to_check();
      if (c_shf) begin
        nshf++;
        bits = {bits[6:0], c_ser};
      end
      chk("w8_done", c, c_done, (c == 9));
      if (c == 9) chk("w8_sipo", c, c_sipo, 8'hC3);
    end
    chk("w8_nshf", 0, nshf, 8);
    chk("w8_bits", 0, bits, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
